// File: rtl/grayscale_frame_writer_if.sv
// Pixel-stream input and frame-buffer write port of the grayscale frame writer.
// master = pixel source / buffer observer, slave = the frame writer itself.
interface grayscale_frame_writer_if;
    logic [7:0]  pixel_in;
    logic        valid;
    logic        sof;
    logic [18:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        sync_err;

    modport master (
        output pixel_in, valid, sof,
        input  mem_addr, mem_data, mem_wren, busy, frame_done, frame_count, sync_err
    );

    modport slave (
        input  pixel_in, valid, sof,
        output mem_addr, mem_data, mem_wren, busy, frame_done, frame_count, sync_err
    );
endinterface

// File: rtl/grayscale_frame_writer.sv
// Grayscale frame writer: turns a raster pixel stream framed by sof into
// row-major frame-buffer writes (addr = y*WIDTH + x) with one cycle of latency.
// A sof seen mid-frame restarts the frame at (0,0) and latches sync_err.
module grayscale_frame_writer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                     clk,
    input  logic                     reset,
    grayscale_frame_writer_if.slave  bus
);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t         state;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [18:0]    addr;       // running address, always equal to y*WIDTH + x

    logic [18:0]    mem_addr_p1;
    logic [7:0]     mem_data_p1;
    logic           vld_p1;
    logic           frame_done_p1;
    logic [7:0]     frame_count_q;
    logic           sync_err_q;

    logic           accept;
    logic           last;
    logic [XW-1:0]  cur_x;
    logic [YW-1:0]  cur_y;
    logic [18:0]    cur_addr;

    // Resolve the raster position of the incoming beat; a sof beat is always (0,0).
    always_comb begin
        accept   = bus.valid && (state == WRITE || bus.sof);
        cur_x    = bus.sof ? '0 : x;
        cur_y    = bus.sof ? '0 : y;
        cur_addr = bus.sof ? '0 : addr;
        last     = (cur_x == X_LAST) && (cur_y == Y_LAST);
    end

    // FSM, raster counters and the registered write port (stage p0 -> p1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            addr          <= '0;
            mem_addr_p1   <= '0;
            mem_data_p1   <= '0;
            vld_p1        <= 1'b0;
            frame_done_p1 <= 1'b0;
            frame_count_q <= '0;
            sync_err_q    <= 1'b0;
        end else begin
            vld_p1        <= 1'b0;
            frame_done_p1 <= 1'b0;
            if (accept) begin
                vld_p1      <= 1'b1;
                mem_addr_p1 <= cur_addr;
                mem_data_p1 <= bus.pixel_in;
                if (state == WRITE && bus.sof) begin
                    sync_err_q <= 1'b1;
                end
                if (last) begin
                    state         <= IDLE;
                    x             <= '0;
                    y             <= '0;
                    addr          <= '0;
                    frame_done_p1 <= 1'b1;
                    frame_count_q <= frame_count_q + 8'd1;
                end else begin
                    state <= WRITE;
                    addr  <= cur_addr + 19'd1;
                    if (cur_x == X_LAST) begin
                        x <= '0;
                        y <= cur_y + 1'b1;
                    end else begin
                        x <= cur_x + 1'b1;
                        y <= cur_y;
                    end
                end
            end
        end
    end

    assign bus.mem_addr    = mem_addr_p1;
    assign bus.mem_data    = mem_data_p1;
    assign bus.mem_wren    = vld_p1;
    assign bus.frame_done  = frame_done_p1;
    assign bus.frame_count = frame_count_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.busy        = (state == WRITE);
endmodule

// File: tb/tb_grayscale_frame_writer.sv
// Scoreboard bench for grayscale_frame_writer with a 4x2 frame.
module tb_grayscale_frame_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    grayscale_frame_writer_if bus();

    grayscale_frame_writer #(.WIDTH(4), .HEIGHT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [18:0] addr;
        logic [7:0]  data;
        logic        done;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          wr_count = 0;
    logic        v_edge = 1'b0;
    logic [18:0] last_addr = '0;
    logic [7:0]  last_data = '0;

    // Remember whether a beat was presented at each active edge.
    always @(posedge clk) v_edge <= bus.valid;

    // Outputs return to zero on reset, so the hold reference does too.
    always @(posedge reset) begin
        last_addr = '0;
        last_data = '0;
    end

    // Monitor: pop the scoreboard on every write, check hold behaviour otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_wren) begin
                exp_t e;
                wr_count++;
                total++;
                if (!v_edge) begin
                    bad++;
                    $display("FAIL wren_after_gap: wren=1 valid_prev=%0b want valid_prev=1", v_edge);
                end
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: addr=%0d data=%02h want no write",
                             bus.mem_addr, bus.mem_data);
                end else begin
                    e = q.pop_front();
                    if (bus.mem_addr !== e.addr || bus.mem_data !== e.data || bus.frame_done !== e.done) begin
                        bad++;
                        $display("FAIL write: got addr=%0d data=%02h done=%0b want addr=%0d data=%02h done=%0b",
                                 bus.mem_addr, bus.mem_data, bus.frame_done, e.addr, e.data, e.done);
                    end
                end
                last_addr = bus.mem_addr;
                last_data = bus.mem_data;
            end else begin
                total++;
                if (bus.frame_done !== 1'b0 || bus.mem_addr !== last_addr || bus.mem_data !== last_data) begin
                    bad++;
                    $display("FAIL idle_hold: got addr=%0d data=%02h done=%0b want addr=%0d data=%02h done=0",
                             bus.mem_addr, bus.mem_data, bus.frame_done, last_addr, last_data);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"},  32'(bus.mem_addr),    32'd0);
        check({tag, "_data"},  32'(bus.mem_data),    32'd0);
        check({tag, "_wren"},  32'(bus.mem_wren),    32'd0);
        check({tag, "_busy"},  32'(bus.busy),        32'd0);
        check({tag, "_done"},  32'(bus.frame_done),  32'd0);
        check({tag, "_count"}, 32'(bus.frame_count), 32'd0);
        check({tag, "_serr"},  32'(bus.sync_err),    32'd0);
    endtask

    // One beat presented for one clock; the expected write is queued if any.
    task automatic beat(input logic [7:0] d, input logic s, input bit wr, input int a, input bit dn);
        exp_t e;
        bus.pixel_in = d;
        bus.sof      = s;
        bus.valid    = 1'b1;
        if (wr) begin
            e.addr = 19'(a);
            e.data = d;
            e.done = dn;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.sof   = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] base, input bit gapped);
        for (int i = 0; i < 8; i++) begin
            beat(8'(base + i), (i == 0), 1'b1, i, (i == 7));
            if (gapped) gap(1);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check_zero("reset_pulse");
        reset = 1'b0;
        gap(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_base;
        bus.pixel_in = '0;
        bus.valid    = 1'b0;
        bus.sof      = 1'b0;
        #2;
        check_zero("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;
        gap(1);

        // Full frame, data 0x10..0x17 at addresses 0..7.
        frame(8'h10, 1'b0);
        check("full_busy_after", 32'(bus.busy), 32'd0);
        gap(1);
        check("full_count", 32'(bus.frame_count), 32'd1);

        // Same frame with a gap after every beat.
        frame(8'h10, 1'b1);
        gap(1);
        check("gapped_count", 32'(bus.frame_count), 32'd2);
        check("gapped_serr", 32'(bus.sync_err), 32'd0);

        // Early sof restarts the frame and latches sync_err.
        pulse_reset();
        beat(8'h20, 1'b1, 1'b1, 0, 1'b0);
        check("early_busy", 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 4; i++) beat(8'(8'h20 + i), 1'b0, 1'b1, i, 1'b0);
        beat(8'hAA, 1'b1, 1'b1, 0, 1'b0);
        check("early_serr", 32'(bus.sync_err), 32'd1);
        check("early_count0", 32'(bus.frame_count), 32'd0);
        check("early_busy_kept", 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 7; i++) beat(8'(8'h30 + i), 1'b0, 1'b1, i, (i == 7));
        gap(1);
        check("early_count1", 32'(bus.frame_count), 32'd1);

        // Junk before sof is dropped; sync_err stays latched.
        for (int i = 0; i < 3; i++) beat(8'(8'hE0 + i), 1'b0, 1'b0, 0, 1'b0);
        gap(1);
        check("junk_busy", 32'(bus.busy), 32'd0);
        frame(8'h40, 1'b0);
        gap(1);
        check("junk_count", 32'(bus.frame_count), 32'd2);
        check("serr_sticky", 32'(bus.sync_err), 32'd1);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 5; i++) beat(8'(8'h50 + i), (i == 0), 1'b1, i, 1'b0);
        gap(1);
        check("midrst_busy_before", 32'(bus.busy), 32'd1);
        pulse_reset();
        for (int i = 0; i < 3; i++) beat(8'(8'h60 + i), 1'b0, 1'b0, 0, 1'b0);
        gap(1);
        check("midrst_busy_after", 32'(bus.busy), 32'd0);

        // 256 back-to-back frames wrap frame_count.
        wr_base = wr_count;
        for (int f = 0; f < 256; f++) begin
            frame(8'(f), 1'b0);
            if (f == 254) check("b2b_count255", 32'(bus.frame_count), 32'd255);
        end
        gap(2);
        check("b2b_count_wrap", 32'(bus.frame_count), 32'd0);
        check("b2b_writes", 32'(wr_count - wr_base), 32'd2048);
        check("b2b_serr", 32'(bus.sync_err), 32'd0);
        check("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
